// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: stall vectors, FSM states, enables, PC width.
package pipe_ctrl_pkg;

    localparam int PC_WIDTH = 32;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    // bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 reserved
    localparam logic [5:0] STALL_NONE   = 6'b000000;
    localparam logic [5:0] STALL_ID     = 6'b000111;
    localparam logic [5:0] STALL_EX     = 6'b001111;
    localparam logic [5:0] STALL_FREEZE = 6'b011111;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MC_WAIT = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_ctrl_mc_counter.sv
// Loadable down-counter for multi-cycle EX ops; done flags the final counted cycle.
module mc_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    input  logic         clr,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == W'(1));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: per-stage stalls, multi-cycle EX sequencing, exception flush/redirect.
// Optional PIPE_CTRL_PERF_EN adds stall-cycle performance counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 6,
    parameter int PC_W  = PC_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             ex_mc_start,
    input  logic [CNT_W-1:0] ex_mc_cycles,
    input  logic             excp_req,
    input  logic [PC_W-1:0]  excp_vec,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [PC_W-1:0]  new_pc,
    output logic             busy
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]      perf_id_stall,
    output logic [31:0]      perf_ex_stall
`endif
);

    state_t state;
    logic   mc_go;
    logic   mc_long;
    logic   cnt_dec;
    logic   cnt_clr;
    logic   cnt_done;

    // A zero-length op never stalls; length 1 stalls only the start cycle.
    assign mc_go   = (state == ST_RUN) && !excp_req && ex_mc_start && (ex_mc_cycles != '0);
    assign mc_long = mc_go && (ex_mc_cycles > CNT_W'(1));
    assign cnt_dec = (state == ST_MC_WAIT) && !excp_req;
    assign cnt_clr = (state == ST_MC_WAIT) && excp_req;

    mc_counter #(.W(CNT_W)) u_mc_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (mc_long),
        .load_val (ex_mc_cycles - CNT_W'(1)),
        .dec      (cnt_dec),
        .clr      (cnt_clr),
        .done     (cnt_done)
    );

    always_comb begin
        stall = STALL_NONE;
        case (state)
            ST_RUN: begin
                if (excp_req)         stall = STALL_FREEZE;
                else if (mc_go)       stall = STALL_EX;
                else if (stallreq_id) stall = STALL_ID;
            end
            ST_MC_WAIT: stall = excp_req ? STALL_FREEZE : STALL_EX;
            default:    stall = STALL_NONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_RUN;
            flush  <= DISABLE;
            new_pc <= '0;
            busy   <= DISABLE;
        end else begin
            case (state)
                ST_RUN, ST_MC_WAIT: begin
                    if (excp_req) begin
                        state  <= ST_FLUSH;
                        new_pc <= excp_vec;
                        flush  <= ENABLE;
                        busy   <= ENABLE;
                    end else if (mc_long) begin
                        state <= ST_MC_WAIT;
                        busy  <= ENABLE;
                    end else if ((state == ST_MC_WAIT) && cnt_done) begin
                        state <= ST_RUN;
                        busy  <= DISABLE;
                    end
                end
                default: begin
                    state <= ST_RUN;
                    flush <= DISABLE;
                    busy  <= DISABLE;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            perf_id_stall <= '0;
            perf_ex_stall <= '0;
        end else begin
            if (stall == STALL_ID) perf_id_stall <= perf_id_stall + 32'd1;
            if (stall == STALL_EX) perf_ex_stall <= perf_ex_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios then random traffic against a cycle-count model.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id;
    logic        ex_mc_start;
    logic [5:0]  ex_mc_cycles;
    logic        excp_req;
    logic [31:0] excp_vec;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        busy;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_id_stall;
    logic [31:0] perf_ex_stall;
`endif

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .ex_mc_start  (ex_mc_start),
        .ex_mc_cycles (ex_mc_cycles),
        .excp_req     (excp_req),
        .excp_vec     (excp_vec),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .busy         (busy)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_id_stall(perf_id_stall),
        .perf_ex_stall(perf_ex_stall)
`endif
    );

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] new_pc;
        logic        busy;
        logic [31:0] pid;
        logic [31:0] pex;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: remaining stall cycles of an op, a pending flush, the held PC.
    int          m_rem;
    bit          m_flush;
    logic [31:0] m_pc;
    logic [31:0] m_pid;
    logic [31:0] m_pex;

    function automatic void model_reset();
        m_rem = 0; m_flush = 0; m_pc = '0; m_pid = '0; m_pex = '0;
    endfunction

    task automatic cyc(input bit r, input bit sid, input bit st, input int n,
                       input bit ex, input logic [31:0] vec);
        exp_t e;
        rst = r; stallreq_id = sid; ex_mc_start = st; ex_mc_cycles = 6'(n);
        excp_req = ex; excp_vec = vec;
        if (r) begin
            model_reset();
        end else begin
            e.flush  = m_flush;
            e.busy   = m_flush || (m_rem > 0);
            e.new_pc = m_pc;
            e.pid    = m_pid;
            e.pex    = m_pex;
            if (m_flush) begin
                e.stall = 6'b000000;
                m_flush = 0;
            end else if (ex) begin
                e.stall = 6'b011111;
                m_flush = 1; m_pc = vec; m_rem = 0;
            end else if (m_rem > 0) begin
                e.stall = 6'b001111;
                m_rem--;
            end else if (st && n > 0) begin
                e.stall = 6'b001111;
                m_rem = n - 1;
            end else if (sid) begin
                e.stall = 6'b000111;
            end else begin
                e.stall = 6'b000000;
            end
            if (e.flush) begin
                m_pid = '0; m_pex = '0;
            end else begin
                if (e.stall == 6'b000111) m_pid++;
                if (e.stall == 6'b001111) m_pex++;
            end
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 0, '0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("stall",  32'(stall),  32'(e.stall));
            chk("flush",  32'(flush),  32'(e.flush));
            chk("new_pc", new_pc,      e.new_pc);
            chk("busy",   32'(busy),   32'(e.busy));
`ifdef PIPE_CTRL_PERF_EN
            chk("perf_id_stall", perf_id_stall, e.pid);
            chk("perf_ex_stall", perf_ex_stall, e.pex);
`endif
        end
    end

    initial begin
        model_reset();
        rst = 1; stallreq_id = 0; ex_mc_start = 0; ex_mc_cycles = '0;
        excp_req = 0; excp_vec = '0;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) cyc(1, 0, 0, 0, 0, '0);
        idle(2);

        // Load-use, then N=5; perf counters then read 1 and 5
        cyc(0, 1, 0, 0, 0, '0);
        idle(2);
        cyc(0, 0, 1, 5, 0, '0);
        idle(6);
        // An exception clears perf counters
        cyc(0, 0, 0, 0, 1, 32'h0000_0040);
        idle(3);
        // N=1 and N=0
        cyc(0, 0, 1, 1, 0, '0);
        idle(2);
        cyc(0, 0, 1, 0, 0, '0);
        idle(2);
        // EX wins over load-use; load-use masked and mc_start ignored during MC_WAIT
        cyc(0, 1, 1, 4, 0, '0);
        cyc(0, 1, 0, 0, 0, '0);
        cyc(0, 0, 1, 7, 0, '0);
        cyc(0, 1, 0, 0, 0, '0);
        idle(3);
        // Exception on the 2nd MC_WAIT cycle; inputs ignored during FLUSH
        cyc(0, 0, 1, 5, 0, '0);
        cyc(0, 0, 0, 0, 0, '0);
        cyc(0, 0, 0, 0, 1, 32'h0000_0180);
        cyc(0, 1, 1, 3, 1, 32'hdead_beef);
        idle(3);
        // Reset held 3 cycles mid-MC_WAIT
        cyc(0, 0, 1, 9, 0, '0);
        cyc(0, 0, 0, 0, 0, '0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, '0);
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                for (int j = 0; j < 3; j++) cyc(1, 0, 0, 0, 0, '0);
            end else begin
                cyc(0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 7), $urandom_range(0, 24) == 0, $urandom);
            end
        end
        idle(2);

        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
